zx_ram_arbiter: RTL

Single-port memory arbiter between the SDRAM controller and the three requesters of the ZX8X core: the Z80 bus (opcode/data reads and writes), the video character-pattern fetch during refresh cycles, and the tape-loader DMA writer. It serialises requests into one `rd`/`we` command stream with `ready` handshaking. It returns read data to the winning requester and drives a CPU wait line while a CPU access is stalled. It sits between the CPU/video/tape logic in the top level and the `sdram` instance.

---
 rtl/zx_ram_pkg.sv | 11 +
 rtl/zx_ram_prio.sv | 27 ++
 rtl/zx_ram_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/zx_ram_pkg.sv
// Shared types for the ZX8X RAM arbiter: FSM states, requester identities
// and the width of the access timeout counter.
package zx_ram_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_VID, SRC_CPU, SRC_TAPE} arb_src_t;

  localparam int TIMEOUT_BITS = 4;

endpackage

// File: rtl/zx_ram_prio.sv
// Fixed-priority requester selection: video > CPU > tape, except that a
// starved tape request overrides everything else.
module zx_ram_prio
  import zx_ram_pkg::*;
(
  input  logic     vid_req,
  input  logic     cpu_req,
  input  logic     tape_req,
  input  logic     starve,
  output arb_src_t src
);

  // Pick the winner among the currently pending requests.
  always_comb begin
    src = SRC_NONE;
    if (starve && tape_req) begin
      src = SRC_TAPE;
    end else if (vid_req) begin
      src = SRC_VID;
    end else if (cpu_req) begin
      src = SRC_CPU;
    end else if (tape_req) begin
      src = SRC_TAPE;
    end
  end

endmodule

// File: rtl/zx_ram_arbiter.sv
// Single-port SDRAM arbiter for the ZX8X core: serialises Z80, video
// pattern fetch and tape DMA accesses into one rd/we command stream.
// Build option: define ZX_TAPE_DMA_EN to enable the tape DMA requester;
// without it the tape ports are ignored and tape_ack stays low.
module zx_ram_arbiter
  import zx_ram_pkg::*;
#(
  parameter int TIMEOUT    = 15,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_wait_n,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic [7:0]  vid_dout,
  output logic        vid_ack,
  input  logic        tape_req,
  input  logic [15:0] tape_addr,
  input  logic [7:0]  tape_din,
  output logic        tape_ack,
  output logic        mem_rd,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  input  logic        mem_ready,
  output logic        err
);

  localparam logic [TIMEOUT_BITS-1:0] TLIM       = TIMEOUT_BITS'(TIMEOUT - 1);
  localparam logic [3:0]              STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t              state, state_next;
  arb_src_t                win, grant_src;
  logic                    is_we, tape_live, starve, grant, finish, timed_out;
  logic [TIMEOUT_BITS-1:0] tcnt;
  logic [3:0]              starve_cnt;
  logic [7:0]              rd_data;

`ifdef ZX_TAPE_DMA_EN
  assign tape_live = tape_req;
`else
  assign tape_live = tape_req & 1'b0;
`endif

  assign starve    = (starve_cnt >= STARVE_LIM);
  assign grant     = (state == IDLE) && (win != SRC_NONE);
  assign finish    = (state == WAIT) && (mem_ready || (tcnt == TLIM));
  assign timed_out = (state == WAIT) && !mem_ready && (tcnt == TLIM);
  assign rd_data   = mem_ready ? mem_dout : 8'hFF;

  assign cpu_wait_n = ~(cpu_req & ~cpu_ack);

  zx_ram_prio u_prio (
    .vid_req  (vid_req),
    .cpu_req  (cpu_req),
    .tape_req (tape_live),
    .starve   (starve),
    .src      (win)
  );

  // State register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic plus the one-cycle command and ack strobes.
  always_comb begin
    state_next = state;
    mem_rd     = 1'b0;
    mem_we     = 1'b0;
    cpu_ack    = 1'b0;
    vid_ack    = 1'b0;
    tape_ack   = 1'b0;
    case (state)
      IDLE:  if (grant) state_next = ISSUE;
      ISSUE: begin
        state_next = WAIT;
        mem_rd     = ~is_we;
        mem_we     = is_we;
      end
      WAIT:  if (finish) state_next = DONE;
      DONE: begin
        state_next = IDLE;
        cpu_ack    = (grant_src == SRC_CPU);
        vid_ack    = (grant_src == SRC_VID);
`ifdef ZX_TAPE_DMA_EN
        tape_ack   = (grant_src == SRC_TAPE);
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch winner, direction, address and write data at grant time.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      grant_src <= SRC_NONE;
      is_we     <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else if (grant) begin
      grant_src <= win;
      case (win)
        SRC_VID: begin
          is_we    <= 1'b0;
          mem_addr <= vid_addr;
          mem_din  <= '0;
        end
        SRC_CPU: begin
          is_we    <= cpu_we;
          mem_addr <= cpu_addr;
          mem_din  <= cpu_din;
        end
        default: begin
          is_we    <= 1'b1;
          mem_addr <= tape_addr;
          mem_din  <= tape_din;
        end
      endcase
    end
  end

  // Capture read data (or 8'hFF on timeout) and track the sticky error.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cpu_dout <= '0;
      vid_dout <= '0;
      err      <= 1'b0;
    end else begin
      if (finish && !is_we) begin
        if (grant_src == SRC_CPU) cpu_dout <= rd_data;
        if (grant_src == SRC_VID) vid_dout <= rd_data;
      end
      if (timed_out) err <= 1'b1;
    end
  end

  // WAIT-cycle counter; restarts from zero on every access.
  always_ff @(posedge clk_sys) begin
    if (!reset_n || state != WAIT) tcnt <= '0;
    else                           tcnt <= tcnt + 1'b1;
  end

  // Count grants lost by a pending tape request; any tape grant or an idle
  // tape line clears it.
  always_ff @(posedge clk_sys) begin
    if (!reset_n || !tape_live) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (win == SRC_TAPE) starve_cnt <= '0;
      else                 starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule
